gcd_engine: RTL and testbench



---
 rtl/gcd_if.sv | 24 ++
 rtl/gcd_engine.sv | 134 +++++++++++++
 tb/tb_gcd_engine.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/gcd_if.sv
// gcd_if: operand/result handshake bundle for gcd_engine.
// The master side supplies operands and consumes results. The slave side is the engine.
interface gcd_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gcd_out;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, gcd_out, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, gcd_out, busy
    );
endinterface

// File: rtl/gcd_engine.sv
// gcd_engine: iterative subtract-based GCD with valid/ready handshakes.
// Flow: IDLE accepts an operand pair, CALC performs one subtraction per cycle,
// and DONE holds the result until it is taken.
// Optional macro GCD_ITER_CNT_EN adds a saturating subtraction counter and the
// iter_cnt output port.
module gcd_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gcd_if.slave             bus
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [CNT_W-1:0] iter_cnt
`endif
);

    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_param
        $error("gcd_engine: WIDTH must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] gcd_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] gcd_d;
    logic             finish_d;

`ifdef GCD_ITER_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // The counter sticks at its maximum value instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return (&v) ? v : v + one;
    endfunction
`endif

    // One subtraction step: the larger operand is always the minuend, so no underflow.
    always_comb begin
        finish_d = (a_q == '0) || (b_q == '0) || (a_q == b_q);
        gcd_d    = (a_q == '0) ? b_q : a_q;
        a_d      = a_q;
        b_d      = b_q;
        if (a_q > b_q) begin
            a_d = a_q - b_q;
        end else begin
            b_d = b_q - a_q;
        end
    end

    // Controller and datapath registers. Handshake outputs are registered, so they
    // have no combinational path from in_valid or out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            gcd_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GCD_ITER_CNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a_in;
                        b_q        <= bus.b_in;
`ifdef GCD_ITER_CNT_EN
                        cnt_q      <= '0;
`endif
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CALC: begin
                    if (finish_d) begin
                        gcd_q       <= gcd_d;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        a_q   <= a_d;
                        b_q   <= b_d;
`ifdef GCD_ITER_CNT_EN
                        cnt_q <= sat_inc(cnt_q);
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.gcd_out   = gcd_q;
`ifdef GCD_ITER_CNT_EN
    assign iter_cnt      = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed vectors with a scoreboard queue and an independent monitor.
module tb_gcd_engine;
    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    gcd_if #(.WIDTH(8)) bus ();

`ifdef GCD_ITER_CNT_EN
    logic [15:0] iter_cnt;
`endif

    gcd_engine #(.WIDTH(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt (iter_cnt)
`endif
    );

    typedef struct {
        logic [7:0] g;
        int         it;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   rise_cyc;
    bit   prev_ov;
    bit   idle_pend;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result transfer happens.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov   = 1'b0;
            idle_pend = 1'b0;
        end else begin
            if (idle_pend) begin
                check("idle_in_ready", {31'd0, bus.in_ready}, 1);
                check("idle_out_valid", {31'd0, bus.out_valid}, 0);
                check("idle_busy", {31'd0, bus.busy}, 0);
                idle_pend = 1'b0;
            end
            if (bus.out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got gcd %0d expected no result", bus.gcd_out);
                end else begin
                    e = sb.pop_front();
                    check("gcd_out", {24'd0, bus.gcd_out}, {24'd0, e.g});
                    check("latency", rise_cyc - e.acc, e.it + 1);
`ifdef GCD_ITER_CNT_EN
                    check("iter_cnt", {16'd0, iter_cnt}, e.it);
`endif
                    idle_pend = 1'b1;
                end
            end
        end
    end

    // Offer one operand pair once the engine is ready; push the expectation on acceptance.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g,
                         input int it, input bit push);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("issue_timeout_in_ready", 0, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (push) sb.push_back('{g, it, cyc});
        check("busy_after_accept", {31'd0, bus.busy}, 1);
        check("in_ready_after_accept", {31'd0, bus.in_ready}, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || idle_pend) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int n;
        cyc           = 0;
        tests         = 0;
        fails         = 0;
        rise_cyc      = 0;
        prev_ov       = 1'b0;
        idle_pend     = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_gcd_out", {24'd0, bus.gcd_out}, 0);
`ifdef GCD_ITER_CNT_EN
        check("rst_iter_cnt", {16'd0, iter_cnt}, 0);
`endif
        rst_n = 1'b1;

        // Basic and zero-operand vectors.
        issue(8'd12, 8'd8, 8'd4, 2, 1'b1);
        drain();
        issue(8'd48, 8'd18, 8'd6, 4, 1'b1);
        drain();
        issue(8'd0, 8'd7, 8'd7, 0, 1'b1);
        drain();
        issue(8'd5, 8'd0, 8'd5, 0, 1'b1);
        drain();
        issue(8'd0, 8'd0, 8'd0, 0, 1'b1);
        drain();
        issue(8'd1, 8'd255, 8'd1, 254, 1'b1);
        drain();
        issue(8'd255, 8'd255, 8'd255, 0, 1'b1);
        drain();

        // Back-pressure: result held while out_ready is low; new operands ignored.
        bus.out_ready = 1'b0;
        issue(8'd9, 8'd6, 8'd3, 2, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_out_valid_rise", {31'd0, bus.out_valid}, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.in_valid = 1'b1;
                bus.a_in     = 8'd100;
                bus.b_in     = 8'd10;
            end
            if (i == 5) bus.in_valid = 1'b0;
            @(posedge clk); #1;
            check("bp_hold_valid", {31'd0, bus.out_valid}, 1);
            check("bp_hold_gcd", {24'd0, bus.gcd_out}, 3);
            check("bp_hold_in_ready", {31'd0, bus.in_ready}, 0);
        end
        bus.out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_extra_busy", {31'd0, bus.busy}, 0);

        // Reset in the middle of a long calculation discards it.
        issue(8'd1, 8'd200, 8'd1, 199, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, bus.busy}, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 1);
        check("midrst_busy", {31'd0, bus.busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(8'd21, 8'd14, 8'd7, 2, 1'b1);
        drain();
        repeat (5) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
